imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter: DEPTH, 2, output FIFO entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  request present.
REQ-005 SHALL have port: in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-006 SHALL have port: in_op  input  2  enc_op_t (LDUR, STUR, CBZ, reserved).
REQ-007 SHALL have port: in_imm  input  64  signed byte/word offset to pack.
REQ-008 SHALL have port: in_rn  input  5  base register (D-format only).
REQ-009 SHALL have port: in_rt  input  5  target register.
REQ-010 SHALL have port: out_valid  output  1  encoded word available.
REQ-011 SHALL have port: out_ready  input  1  consumer takes word when high with out_valid.
REQ-012 SHALL have port: out_instr  output  32  encoded LEGv8 instruction.
REQ-013 SHALL have port: out_err  output  1  range or opcode error for out_instr.
REQ-014 SHALL have port: enc_count  output  16  words accepted, saturating.
REQ-015 SHALL have port: err_count  output  16  erroneous words accepted, saturating.

Function
REQ-016 SHALL encode LDUR/STUR as opcode 11111000010/11111000000 in [31:21], imm[8:0] in [20:12], 00 in [11:10], rn in [9:5], rt in [4:0].
REQ-017 SHALL encode CBZ as 10110100 in [31:24], imm[18:0] in [23:5], rt in [4:0]; in_rn ignored.
REQ-018 SHALL set out_err when in_imm is outside signed 9-bit range (-256..255) for D-format or signed 19-bit range for CBZ; field still carries truncated low bits.
REQ-019 SHALL, for reserved in_op, produce out_instr = 32'h0 with out_err = 1.
REQ-020 SHALL guarantee that for every error-free word, sign-extending the packed field reproduces in_imm exactly.
REQ-021 SHALL accept a request on a rising edge where in_valid and in_ready are both high; encoding is registered into the FIFO at that edge.
REQ-022 SHALL drive in_ready = FIFO not full; no same-cycle bypass when full (a pop while full frees a slot only on the next cycle).
REQ-023 SHALL present an accepted word on out_valid one cycle after acceptance when the FIFO was empty (latency 1).
REQ-024 SHALL pop one entry per edge where out_valid and out_ready are high; simultaneous push and pop when partially full leaves occupancy unchanged.
REQ-025 SHALL hold out_instr/out_err stable while out_valid is high and out_ready low.
REQ-026 SHALL preserve strict FIFO order; pointers wrap modulo DEPTH.
REQ-027 SHALL increment enc_count on every accept and err_count on every erroneous accept, each saturating at 16'hFFFF.

Reset
REQ-028 SHALL, on reset low, asynchronously clear FIFO pointers and occupancy, out_valid = 0, out_instr = 0, out_err = 0, enc_count = 0, err_count = 0; in_ready = 1 after release.
REQ-029 SHALL discard any in-flight or buffered words when reset asserts mid-operation; no word survives reset.

Structure
REQ-030 SHALL place enc_op_t and the three opcode constants in shared package legv8_pkg.
REQ-031 SHALL implement buffering as sub-module enc_fifo (parameter DEPTH, width 33 = {err, instr}); encoding logic stays in imm_encoder.

Verification
REQ-032 SHALL cover: LDUR imm=0x2D rn=1 rt=2 -> out_instr 32'hF842D022, out_err 0, one cycle after accept.
REQ-033 SHALL cover: CBZ imm=-4 rt=3 -> out_instr 32'hB4FFFF83, out_err 0.
REQ-034 SHALL cover: STUR imm=256 -> out_err 1, err_count increments; imm=-256 -> out_err 0.
REQ-035 SHALL cover: out_ready held low, 3 requests -> in_ready low after 2, third held; release out_ready -> words emerge in order.
REQ-036 SHALL cover: reset asserted with 2 buffered words -> out_valid 0 immediately, counters 0, no stale word after release.
REQ-037 SHALL cover: reserved in_op -> out_instr 32'h0, out_err 1; enc_count preset near 16'hFFFF saturates.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: operation selector, opcode constants
// and immediate range helpers used by the encoder.
package legv8_pkg;

  typedef enum logic [1:0] {
    OP_LDUR = 2'd0,
    OP_STUR = 2'd1,
    OP_CBZ  = 2'd2,
    OP_RSVD = 2'd3
  } enc_op_t;

  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  localparam int unsigned ENC_W = 33;

  // A value fits a signed N-bit field when every bit above the field's sign bit copies it.
  function automatic logic fits_d9(input logic [63:0] imm);
    return imm[63:8] == {56{imm[8]}};
  endfunction

  function automatic logic fits_cb19(input logic [63:0] imm);
    return imm[63:18] == {46{imm[18]}};
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Registered-flag FIFO holding encoded words; full/valid come straight from
// flops so in_ready and out_valid are glitch-free registered outputs.
module enc_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // A push while full is refused even if a pop happens the same edge.
  assign push_ok_s = push_i & ~full_q;
  assign pop_ok_s  = pop_i & valid_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != CW'(0));
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      count_q  <= CW'(0);
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  // Storage is cleared too so the head reads as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign full_o  = full_q;
  assign valid_o = valid_q;
  assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/imm_encoder.sv
// Packs LDUR/STUR/CBZ requests into 32-bit LEGv8 words with range checking,
// buffers them in a small FIFO and keeps saturating accept/error counters.
module imm_encoder
  import legv8_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  enc_op_t     in_op,
  input  logic [63:0] in_imm,
  input  logic [4:0]  in_rn,
  input  logic [4:0]  in_rt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  logic [31:0]      instr_s;
  logic             err_s;
  logic             accept_s;
  logic             fifo_full_s;
  logic             fifo_valid_s;
  logic [ENC_W-1:0] fifo_data_s;
  logic [15:0]      enc_count_q, enc_count_d;
  logic [15:0]      err_count_q, err_count_d;

  // Out-of-range immediates still pack their truncated low bits; only the flag marks them.
  always_comb begin
    instr_s = 32'h0;
    err_s   = 1'b0;
    case (in_op)
      OP_LDUR: begin
        instr_s = {OPC_LDUR, in_imm[8:0], 2'b00, in_rn, in_rt};
        err_s   = ~fits_d9(in_imm);
      end
      OP_STUR: begin
        instr_s = {OPC_STUR, in_imm[8:0], 2'b00, in_rn, in_rt};
        err_s   = ~fits_d9(in_imm);
      end
      OP_CBZ: begin
        instr_s = {OPC_CBZ, in_imm[18:0], in_rt};
        err_s   = ~fits_cb19(in_imm);
      end
      default: begin
        instr_s = 32'h0;
        err_s   = 1'b1;
      end
    endcase
  end

  assign accept_s = in_valid & ~fifo_full_s;

  always_comb begin
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (accept_s && (enc_count_q != 16'hFFFF)) begin
      enc_count_d = enc_count_q + 16'd1;
    end else begin
      enc_count_d = enc_count_q;
    end
    if (accept_s && err_s && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enc_count_q <= 16'h0;
      err_count_q <= 16'h0;
    end else begin
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENC_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (accept_s),
    .push_data_i ({err_s, instr_s}),
    .pop_i       (out_ready),
    .full_o      (fifo_full_s),
    .valid_o     (fifo_valid_s),
    .data_o      (fifo_data_s)
  );

  assign in_ready  = ~fifo_full_s;
  assign out_valid = fifo_valid_s;
  assign out_err   = fifo_data_s[32];
  assign out_instr = fifo_data_s[31:0];
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: accepted requests are modelled and queued,
// a monitor compares every presented word against the queue head.
module tb_imm_encoder;
  import legv8_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  enc_op_t     in_op = OP_LDUR;
  logic [63:0] in_imm = 64'd0;
  logic [4:0]  in_rn = 5'd0;
  logic [4:0]  in_rt = 5'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    longint      imm;
    logic [1:0]  op;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  longint n_acc = 0;
  longint n_err = 0;
  longint bnd[8] = '{255, 256, -256, -257, 262143, 262144, -262144, -262145};

  always #5 clk = ~clk;

  imm_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_imm    (in_imm),
    .in_rn     (in_rn),
    .in_rt     (in_rt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: field values by modular arithmetic, errors by numeric range.
  function automatic exp_t model(input logic [1:0] op, input logic [63:0] imm,
                                 input logic [4:0] rn, input logic [4:0] rt);
    exp_t e;
    longint s;
    logic [63:0] w;
    s = longint'(imm);
    e.imm = s;
    e.op = op;
    case (op)
      2'd0, 2'd1: begin
        e.err = (s < -256) || (s > 255);
        w = ((op == 2'd0) ? 64'd1986 : 64'd1984) * 64'd2097152
            + (imm % 64'd512) * 64'd4096 + 64'(rn) * 64'd32 + 64'(rt);
      end
      2'd2: begin
        e.err = (s < -262144) || (s > 262143);
        w = 64'd180 * 64'd16777216 + (imm % 64'd524288) * 64'd32 + 64'(rt);
      end
      default: begin
        e.err = 1'b1;
        w = 64'd0;
      end
    endcase
    e.instr = w[31:0];
    return e;
  endfunction

  function automatic logic [15:0] sat16(input longint n);
    logic [63:0] v;
    v = n;
    return (n > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  // Stimulus side of the scoreboard: record each accepted request.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      n_acc = 0;
      n_err = 0;
    end else if (in_valid && in_ready) begin
      e = model(in_op, in_imm, in_rn, in_rt);
      exp_q.push_back(e);
      n_acc++;
      if (e.err) n_err++;
    end
  end

  // Monitor: compare the presented word every cycle it is valid, pop on handshake.
  always @(negedge clk) begin
    exp_t   e;
    longint f;
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {32'd0, out_instr}, 64'hDEAD_0000_0000_0000);
      end else begin
        e = exp_q[0];
        chk("out_instr", {32'd0, out_instr}, {32'd0, e.instr});
        chk("out_err", {63'd0, out_err}, {63'd0, e.err});
        if (!e.err) begin
          if (e.op == 2'd2) f = longint'($signed(out_instr[23:5]));
          else f = longint'($signed(out_instr[20:12]));
          chk("roundtrip", f, e.imm);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [63:0] imm,
                      input logic [4:0] rn, input logic [4:0] rt);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_op = enc_op_t'(op);
    in_imm = imm;
    in_rn = rn;
    in_rt = rt;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_enc_count"}, {48'd0, enc_count}, {48'd0, sat16(n_acc)});
    chk({tag, "_err_count"}, {48'd0, err_count}, {48'd0, sat16(n_err)});
  endtask

  initial begin
    longint v;
    int w;
    cyc(2);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    chk("rst_enc_count", {48'd0, enc_count}, 64'd0);
    chk("rst_err_count", {48'd0, err_count}, 64'd0);
    reset = 1'b1;
    cyc(1);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    send(2'd0, 64'h2D, 5'd1, 5'd2);
    chk("ldur_latency_valid", {63'd0, out_valid}, 64'd1);
    chk("ldur_word", {32'd0, out_instr}, 64'hF842D022);
    chk("ldur_err", {63'd0, out_err}, 64'd0);
    out_ready = 1'b1;
    cyc(1);
    send(2'd2, -64'sd4, 5'd9, 5'd3);
    chk("cbz_word", {32'd0, out_instr}, 64'hB4FFFF83);
    chk("cbz_err", {63'd0, out_err}, 64'd0);
    send(2'd1, 64'd256, 5'd4, 5'd5);
    chk("stur_256_err", {63'd0, out_err}, 64'd1);
    send(2'd1, -64'sd256, 5'd4, 5'd5);
    chk("stur_m256_err", {63'd0, out_err}, 64'd0);
    for (int i = 0; i < 8; i++) send(2'(i % 3), bnd[i], 5'(i), 5'(i + 7));
    cyc(3);
    chk_counts("directed");

    // Back-pressure: two fill the FIFO, the third must wait.
    out_ready = 1'b0;
    send(2'd0, 64'd10, 5'd1, 5'd1);
    send(2'd1, 64'd20, 5'd2, 5'd2);
    in_valid = 1'b1;
    in_op = OP_CBZ;
    in_imm = 64'd30;
    in_rt = 5'd3;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    end
    chk("full_hold_count", {48'd0, enc_count}, {48'd0, sat16(n_acc)});
    out_ready = 1'b1;
    send(2'd2, 64'd30, 5'd0, 5'd3);
    cyc(4);
    chk_counts("backpressure");

    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1);
      in_op = enc_op_t'($urandom_range(0, 3));
      in_rn = 5'($urandom);
      in_rt = 5'($urandom);
      case ($urandom_range(0, 3))
        0: v = longint'($urandom_range(0, 600)) - 300;
        1: v = longint'($urandom_range(0, 600000)) - 300000;
        2: v = bnd[$urandom_range(0, 7)];
        default: v = longint'({$urandom, $urandom});
      endcase
      in_imm = v;
      cyc(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc(4);
    chk_counts("random");

    // Reset with two words buffered.
    out_ready = 1'b0;
    send(2'd0, 64'd1, 5'd1, 5'd1);
    send(2'd0, 64'd2, 5'd2, 5'd2);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("midrst_enc_count", {48'd0, enc_count}, 64'd0);
    chk("midrst_err_count", {48'd0, err_count}, 64'd0);
    cyc(2);
    reset = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
    cyc(3);
    chk("postrst_no_stale", {63'd0, out_valid}, 64'd0);

    send(2'd3, 64'h1234, 5'd1, 5'd1);
    chk("rsvd_word", {32'd0, out_instr}, 64'd0);
    chk("rsvd_err", {63'd0, out_err}, 64'd1);

    // Drive past the counter ceiling with reserved ops so both counters saturate.
    in_valid = 1'b1;
    in_op = OP_RSVD;
    in_imm = 64'h55;
    cyc(65540);
    in_valid = 1'b0;
    cyc(4);
    chk("sat_enc_count", {48'd0, enc_count}, 64'hFFFF);
    chk("sat_err_count", {48'd0, err_count}, 64'hFFFF);
    chk_counts("saturated");

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      cyc(1);
      w++;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
